// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : md_ctrl
//  Purpose  : Multi-cycle multiply/divide controller owning the HI/LO pair.
//             The result of mult/multu/div/divu is computed and captured on
//             the issue edge, then held for a fixed busy period before it is
//             committed to HI/LO. mthi/mtlo write HI/LO directly when idle.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous, active-high reset
//             start  - qualified E-stage md-unit operation this cycle
//             md_op  - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 nop
//             A, B   - forwarded rs / rt operands
//             busy   - registered, operation in flight
//             HI, LO - architectural HI / LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;

  // Products: operands are extended to 64 bits so the low 64 bits of the
  // modular product equal the exact signed/unsigned result.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Division shares one unsigned divider. Signed division works on
  // magnitudes and fixes signs afterwards; this also makes INT_MIN / -1
  // come out as 0x80000000 with no overflow trap.
  logic        sdiv;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  assign sdiv     = ~md_op[0];
  assign abs_a    = A[31] ? (~A + 32'd1) : A;
  assign abs_b    = B[31] ? (~B + 32'd1) : B;
  assign dvd      = sdiv ? abs_a : A;
  assign dvs      = sdiv ? abs_b : B;
  // Avoid an X-producing divide when B is zero; that result is never committed.
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign uq       = dvd / dvs_safe;
  assign ur       = dvd % dvs_safe;
  assign quo      = (sdiv && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
  assign rem      = (sdiv && A[31]) ? (~ur + 32'd1) : ur;
  assign div_zero = (B == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      busy    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0: begin
                {pend_hi, pend_lo} <= prod_s;
                pend_dz <= 1'b0;
                cnt     <= MULT_CNT;
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'd1: begin
                {pend_hi, pend_lo} <= prod_u;
                pend_dz <= 1'b0;
                cnt     <= MULT_CNT;
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'd2, 3'd3: begin
                pend_lo <= quo;
                pend_hi <= rem;
                pend_dz <= div_zero;
                cnt     <= DIV_CNT;
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored for the whole run, including the commit edge.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!pend_dz) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_ctrl
//  Purpose  : Directed self-checking bench for md_ctrl (MULT_CYCLES=5,
//             DIV_CYCLES=10). Inputs change and outputs are sampled 1 time
//             unit after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  md_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic [31:0] h, input logic [31:0] l);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_hi"}, HI, h);
    chk({tag, "_lo"}, LO, l);
  endtask

  // Drive one start pulse during the current cycle N; returns sampling N+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    md_op = 3'd7;
  endtask

  // Expect busy high for k cycles with HI/LO held, then the committed result.
  task automatic run_op(input string tag, input int k,
                        input logic [31:0] old_h, input logic [31:0] old_l,
                        input logic [31:0] new_h, input logic [31:0] new_l);
    for (int i = 0; i < k; i++) begin
      chk({tag, "_run"}, {31'd0, busy}, 32'd1);
      if (i == k - 1) begin
        chk({tag, "_hold_hi"}, HI, old_h);
        chk({tag, "_hold_lo"}, LO, old_l);
      end
      tick();
    end
    chk_out({tag, "_done"}, 1'b0, new_h, new_l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd7;
    A     = 32'd0;
    B     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset", 1'b0, 32'h0, 32'h0);

    // mult -2 * 3 = -6
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    run_op("mult_neg", 5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    run_op("multu", 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFE);

    // div -7 / 2 = -3 rem -1
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    run_op("div_neg", 10, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // divu 7 / 0: full busy period, HI/LO unchanged
    issue(3'd3, 32'd7, 32'd0);
    run_op("divu_zero", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // div 7 / -2 = -3 rem 1
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    run_op("div_negb", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD);

    // div INT_MIN / -1 = INT_MIN rem 0
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_ovf", 10, 32'h00000001, 32'hFFFFFFFD, 32'h00000000, 32'h80000000);

    // divu 0xFFFFFFFF / 16 = 0x0FFFFFFF rem 15
    issue(3'd3, 32'hFFFFFFFF, 32'h10);
    run_op("divu", 10, 32'h00000000, 32'h80000000, 32'h0000000F, 32'h0FFFFFFF);

    // signed div by zero is also suppressed
    issue(3'd2, 32'hFFFFFFF0, 32'd0);
    run_op("div_zero", 10, 32'h0000000F, 32'h0FFFFFFF, 32'h0000000F, 32'h0FFFFFFF);

    // mthi then mtlo back to back
    issue(3'd4, 32'h12345678, 32'd0);
    chk_out("mthi", 1'b0, 32'h12345678, 32'h0FFFFFFF);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    chk_out("mtlo", 1'b0, 32'h12345678, 32'h9ABCDEF0);

    // md_op 6/7 do nothing
    issue(3'd6, 32'h55555555, 32'd1);
    chk_out("nop6", 1'b0, 32'h12345678, 32'h9ABCDEF0);
    issue(3'd7, 32'h66666666, 32'd1);
    chk_out("nop7", 1'b0, 32'h12345678, 32'h9ABCDEF0);

    // mult 3*4 with mtlo pulses at busy cycle 2 and on the commit cycle
    issue(3'd0, 32'd3, 32'd4);                  // now busy cycle 1
    chk("ign_c1", {31'd0, busy}, 32'd1);
    tick();                                     // busy cycle 2
    start = 1'b1; md_op = 3'd5; A = 32'hDEAD; B = 32'd0;
    chk("ign_c2", {31'd0, busy}, 32'd1);
    tick();                                     // busy cycle 3
    start = 1'b0; md_op = 3'd7;
    chk_out("ign_c3", 1'b1, 32'h12345678, 32'h9ABCDEF0);
    tick();                                     // busy cycle 4
    tick();                                     // busy cycle 5 (commit)
    chk_out("ign_c5", 1'b1, 32'h12345678, 32'h9ABCDEF0);
    start = 1'b1; md_op = 3'd5; A = 32'hDEAD;
    tick();
    start = 1'b0; md_op = 3'd7;
    chk_out("ign_done", 1'b0, 32'h0, 32'd12);
    tick();
    chk_out("ign_after", 1'b0, 32'h0, 32'd12);

    // div 100/7 aborted by reset at busy cycle 4
    issue(3'd2, 32'd100, 32'd7);                // busy cycle 1
    tick();
    tick();
    chk("abort_c3", {31'd0, busy}, 32'd1);
    tick();                                     // busy cycle 4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("abort_rst", 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    chk_out("abort_nocommit", 1'b0, 32'h0, 32'h0);

    // fresh mult after the abort: 0x7FFFFFFF^2
    issue(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    run_op("mult_post", 5, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
